// File: rtl/async_mixed_reset_flops.sv
// Three single-bit flags that share d/e/r but each use a different reset style:
// q[0] clears synchronously on r=1, q[1] clears asynchronously on r=1, q[2] resets asynchronously on r=0.
module async_mixed_reset_flops (
  input  logic       clk,
  input  logic       r,
  input  logic       d,
  input  logic       e,
  output logic [2:0] q
);

  logic q0, q1, q2;

  // r is only sampled at the clock edge; changes between edges are invisible here
  always_ff @(posedge clk) begin
    if (r)      q0 <= 1'b0;
    else if (e) q0 <= d;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r)      q1 <= 1'b0;
    else if (e) q1 <= d;
  end

  // Enable is inverted for this bit: it loads while e is low
  always_ff @(posedge clk or negedge r) begin
    if (!r)     q2 <= 1'b0;
    else if (!e) q2 <= d;
  end

  assign q = {q2, q1, q0};

endmodule

// File: tb/tb_async_mixed_reset_flops.sv
// Directed plus random bench for async_mixed_reset_flops; per-bit reference model with a known mask.
module tb_async_mixed_reset_flops;

  logic       clk = 1'b0;
  logic       r, d, e;
  logic [2:0] q;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: value per bit plus whether that bit has been defined yet
  logic [2:0] m_val = 3'b000;
  logic [2:0] m_known = 3'b000;
  bit         run_cmp = 1'b0;

  async_mixed_reset_flops dut (
    .clk (clk),
    .r   (r),
    .d   (d),
    .e   (e),
    .q   (q)
  );

  always #5 clk = ~clk;

  // Clocked rules, one per bit, evaluated from the inputs present at the edge
  always @(posedge clk) begin
    if (r === 1'b1) begin
      m_val[0] = 1'b0; m_known[0] = 1'b1;
    end else if (e === 1'b1) begin
      m_val[0] = d; m_known[0] = 1'b1;
    end
    if (r === 1'b0 && e === 1'b1) begin
      m_val[1] = d; m_known[1] = 1'b1;
    end
    if (r === 1'b1 && e === 1'b0) begin
      m_val[2] = d; m_known[2] = 1'b1;
    end
  end

  // Level of r after any edge: high clears q1, low clears q2, no clock needed
  always @(r) begin
    if (r === 1'b1) begin
      m_val[1] = 1'b0; m_known[1] = 1'b1;
    end else if (r === 1'b0) begin
      m_val[2] = 1'b0; m_known[2] = 1'b1;
    end
  end

  // Mid-cycle comparison of every defined bit against the model
  always @(negedge clk) begin
    if (run_cmp && m_known != 3'b000) begin
      n_cmp++;
      if ((q & m_known) !== (m_val & m_known)) begin
        n_err++;
        $display("FAIL model_cmp t=%0t q=%b expected=%b mask=%b", $time, q, m_val, m_known);
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] exp, input logic [2:0] mask);
    n_cmp++;
    if ((q & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s t=%0t q=%b expected=%b mask=%b", name, $time, q, exp, mask);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    r = 1'b1; d = 1'b0; e = 1'b0;
    #1 r = 1'b0;
    #1 chk("init_q2_async", 3'b000, 3'b100);
    run_cmp = 1'b1;

    e = 1'b1;
    step();
    chk("init_load_zero", 3'b000, 3'b111);

    d = 1'b1;
    step();
    chk("load_011", 3'b011, 3'b111);

    e = 1'b0; d = 1'b0;
    step();
    chk("hold_011", 3'b011, 3'b111);

    r = 1'b1;
    #1 chk("async_q1_clear", 3'b001, 3'b111);
    step();
    chk("sync_q0_clear", 3'b000, 3'b111);

    d = 1'b1;
    step();
    chk("q2_inv_enable", 3'b100, 3'b111);

    #1 r = 1'b0;
    #1 chk("async_q2_reset", 3'b000, 3'b111);
    step();
    chk("after_release", 3'b000, 3'b111);

    r = 1'b1; e = 1'b1; d = 1'b1;
    step();
    chk("prio_clear_over_en", 3'b000, 3'b111);

    e = 1'b0;
    step();
    chk("prio_q2_load", 3'b100, 3'b111);

    // Enabled load with r low picks up q0/q1, q2 must hold at 1 until r drops
    r = 1'b0;
    #1 chk("q2_drop_again", 3'b000, 3'b111);
    e = 1'b1;
    step();
    chk("reload_011", 3'b011, 3'b111);

    for (int i = 0; i < 1000; i++) begin
      d = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
